mc_mainfsm: RTL and testbench
=============================

// Module: mc_mainfsm
// PURPOSE
// Main control FSM for the multicycle ARM datapath (integer, MUL/UMULL, FP paths).
// Moore machine: sequences fetch/decode/execute/writeback; drives datapath mux
// selects and write enables. ALUOp feeds the ALU decoder. NextPC/Branch feed
// condition logic, which forms PCWrite. Multiply and FP execute hold for
// parameterised latencies.
// PARAMETERS
// MUL_LAT  1  cycles in MULEX before MULWB (>=1)
// FPU_LAT  1  cycles in FPEX before FPWB (>=1)
// PORTS
// clk         in   1  clock, rising edge
// reset       in   1  asynchronous, active-low reset
// Op          in   2  Instr[27:26]
// Funct       in   6  Instr[25:20]
// MulBits     in   4  Instr[7:4]
// NextPC      out  1  PC update request (unconditional)
// Branch      out  1  branch state; gated by CondEx externally
// RegW        out  1  integer regfile write request (pre-condition)
// MemW        out  1  memory write request (pre-condition)
// FpuW        out  1  FP regfile write request (pre-condition)
// IRWrite     out  1  instruction register enable
// AdrSrc      out  1  0=PC, 1=Result
// ALUSrcA     out  2  bit0: 0=A, 1=PC; bit1 always 0
// ALUSrcB     out  2  00=WriteData, 01=ExtImm, 10=const 4
// ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
// ALUOp       out  1  1 = ALU decoder uses Funct/mul decode; 0 = add
// RegSrcMul   out  1  mul register-field remap
// lmulFlag    out  1  64-bit (UMULL) dual writeback
// InstrRetire out  1  high in the last state of each instruction
// BEHAVIOUR
// - Reset low: state=FETCH, counter=0. All write enables forced 0 while reset low:
//   IRWrite, NextPC, RegW, MemW, FpuW and InstrRetire. Selects take FETCH values.
// - Outputs decode combinationally from state; defaults are 0. is_mul = Op==00 &
//   Funct[5]==0 & MulBits==1001. is_fp = Op==11 & Funct[5:4]==10.
// - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10;
//   next state DECODE.
// - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
//   Next state: Op=01 -> MEMADR; Op=10 -> BRANCH; is_mul -> MULEX.
//   Op=00 & Funct[5] -> EXECUTEI; Op=00 otherwise -> EXECUTER.
//   is_fp -> FPEX; other Op=11 -> FETCH (undefined instruction; InstrRetire=1).
// - MEMADR: ALUSrcB=01; next MEMRD if Funct[0] else MEMWR.
// - MEMRD: AdrSrc=1, ResultSrc=00; next MEMWB.
// - MEMWB: ResultSrc=01, RegW=1; next FETCH.
// - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1; next FETCH.
// - EXECUTER (ALUSrcB=00) / EXECUTEI (ALUSrcB=01): ALUOp=1; next ALUWB.
// - ALUWB: ResultSrc=00, RegW=1; next FETCH.
// - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1; next FETCH.
// - MULEX: ALUOp=1, ALUSrcB=00. On entry cnt<=MUL_LAT-1; decrement each cycle;
//   leave for MULWB when cnt==0. MUL_LAT=1 gives exactly one MULEX cycle.
// - MULWB: RegW=1, ResultSrc=00, lmulFlag=Funct[3]; next FETCH.
// - RegSrcMul=1 whenever is_mul and state is DECODE, MULEX or MULWB.
// - FPEX: counter semantics as MULEX, using FPU_LAT; then FPWB.
// - FPWB: FpuW=1; next FETCH.
// - InstrRetire=1 in MEMWB, MEMWR, ALUWB, BRANCH, MULWB, FPWB and undefined DECODE.
// - Latency in cycles: data-proc 4, ldr 5, str 4, b 3, mul 4+MUL_LAT-1,
//   fp 4+FPU_LAT-1.
// - Reset asserted mid-instruction aborts it; no write enable rises afterwards.
//   First FETCH is on the first rising edge after reset release.
// STRUCTURE
// - mc_ctrl_pkg: state enum (FETCH..FPWB, 4 bits) and select constants
//   (SRCB_*, RES_*, ADR_*). Shared with the decoder and testbench.
// - Single module: state register plus latency counter (width $clog2(max LAT)+1).
//   No sub-module.
// TESTING
// - Reset low 3 cycles, then high -> during reset IRWrite=0, NextPC=0;
//   state FETCH; after release IRWrite=1 on cycle 0.
// - ADD R1,R2,R3 (Op=00, Funct=001000) -> FETCH, DECODE, EXECUTER, ALUWB;
//   RegW=1 only in cycle 3; InstrRetire pulses once.
// - LDR (Op=01, Funct[0]=1) -> 5 states; AdrSrc=1 in MEMRD; ResultSrc=01, RegW in MEMWB.
//   STR -> MemW=1 in cycle 3 only.
// - UMULL (Funct=001001, MulBits=1001), MUL_LAT=3 -> MULEX held 3 cycles;
//   MULWB has RegW=1, lmulFlag=1; RegSrcMul high from DECODE through MULWB.
// - FP op (Op=11, Funct=100000), FPU_LAT=2 -> FPEX 2 cycles, then FpuW=1 one cycle.
//   Op=11, Funct=000000 -> back to FETCH with no writes.
// - Reset low during MULEX cycle 2 -> next cycle state FETCH, all enables 0,
//   no RegW pulse ever seen.

Source files
------------

// File: rtl/mc_mainfsm_pkg.sv
// mc_mainfsm_pkg: shared definitions for the multicycle ARM main control FSM.
// Holds the 4-bit state encoding, the datapath select codes driven by the
// FSM, and small helpers that classify the instruction fields.
package mc_mainfsm_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        MULEX,
        MULWB,
        FPEX,
        FPWB
    } state_e;

    // Instr[27:26] opcode classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_FP  = 2'b11;

    // ALU source A select
    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    // ALU source B select
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Memory address select
    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    localparam logic [3:0] MULBITS_MUL = 4'b1001;

    // Multiply: data-processing class, register form, Instr[7:4]==1001
    function automatic logic is_mul_instr(input logic [1:0] op,
                                          input logic [5:0] funct,
                                          input logic [3:0] mulbits);
        return (op == OP_DP) && !funct[5] && (mulbits == MULBITS_MUL);
    endfunction

    function automatic logic is_fp_instr(input logic [1:0] op,
                                         input logic [5:0] funct);
        return (op == OP_FP) && (funct[5:4] == 2'b10);
    endfunction

endpackage

// File: rtl/mc_mainfsm_if.sv
// mc_mainfsm_if: instruction fields into the main FSM and the control
// outputs it drives into the datapath / condition logic.
//   slave  : FSM side (reads instruction fields, drives controls)
//   master : datapath side (drives instruction fields, reads controls)
interface mc_mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] MulBits;
    logic       NextPC;
    logic       Branch;
    logic       RegW;
    logic       MemW;
    logic       FpuW;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       RegSrcMul;
    logic       lmulFlag;
    logic       InstrRetire;

    modport slave (
        input  Op, Funct, MulBits,
        output NextPC, Branch, RegW, MemW, FpuW, IRWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegSrcMul, lmulFlag,
               InstrRetire
    );

    modport master (
        output Op, Funct, MulBits,
        input  NextPC, Branch, RegW, MemW, FpuW, IRWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegSrcMul, lmulFlag,
               InstrRetire
    );
endinterface

// File: rtl/mc_mainfsm.sv
// mc_mainfsm: Moore main control FSM for the multicycle ARM datapath
// (integer, MUL/UMULL and FP paths).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - mc_mainfsm_if.slave: Op/Funct/MulBits in, datapath controls out
// Parameters:
//   MUL_LAT - cycles spent in MULEX (>=1)
//   FPU_LAT - cycles spent in FPEX  (>=1)
module mc_mainfsm
    import mc_mainfsm_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int FPU_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    mc_mainfsm_if.slave  bus
);

    localparam int MAX_LAT = (MUL_LAT > FPU_LAT) ? MUL_LAT : FPU_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] FPU_LOAD = CNT_W'(FPU_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_mul, is_fp;

    assign is_mul = is_mul_instr(bus.Op, bus.Funct, bus.MulBits);
    assign is_fp  = is_fp_instr(bus.Op, bus.Funct);

    // Funct[2:1] carry no control meaning for this FSM
    logic unused_funct;
    assign unused_funct = ^bus.Funct[2:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bus.NextPC      = 1'b0;
        bus.Branch      = 1'b0;
        bus.RegW        = 1'b0;
        bus.MemW        = 1'b0;
        bus.FpuW        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.AdrSrc      = ADR_PC;
        bus.ALUSrcA     = SRCA_REG;
        bus.ALUSrcB     = SRCB_WD;
        bus.ResultSrc   = RES_ALUOUT;
        bus.ALUOp       = 1'b0;
        bus.RegSrcMul   = 1'b0;
        bus.lmulFlag    = 1'b0;
        bus.InstrRetire = 1'b0;

        unique case (state_q)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.NextPC    = 1'b1;
                bus.AdrSrc    = ADR_PC;
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
                state_d       = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
                bus.RegSrcMul = is_mul;
                case (bus.Op)
                    OP_MEM: state_d = MEMADR;
                    OP_BR:  state_d = BRANCH;
                    OP_DP: begin
                        if (is_mul) begin
                            state_d = MULEX;
                            cnt_d   = MUL_LOAD;
                        end else if (bus.Funct[5]) begin
                            state_d = EXECUTEI;
                        end else begin
                            state_d = EXECUTER;
                        end
                    end
                    default: begin
                        if (is_fp) begin
                            state_d = FPEX;
                            cnt_d   = FPU_LOAD;
                        end else begin
                            // Undefined encoding: retire without any write
                            state_d         = FETCH;
                            bus.InstrRetire = 1'b1;
                        end
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcB = SRCB_IMM;
                state_d     = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.AdrSrc    = ADR_RESULT;
                bus.ResultSrc = RES_ALUOUT;
                state_d       = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc   = RES_DATA;
                bus.RegW        = 1'b1;
                bus.InstrRetire = 1'b1;
                state_d         = FETCH;
            end
            MEMWR: begin
                bus.AdrSrc      = ADR_RESULT;
                bus.ResultSrc   = RES_ALUOUT;
                bus.MemW        = 1'b1;
                bus.InstrRetire = 1'b1;
                state_d         = FETCH;
            end
            EXECUTER: begin
                bus.ALUOp   = 1'b1;
                bus.ALUSrcB = SRCB_WD;
                state_d     = ALUWB;
            end
            EXECUTEI: begin
                bus.ALUOp   = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = ALUWB;
            end
            ALUWB: begin
                bus.ResultSrc   = RES_ALUOUT;
                bus.RegW        = 1'b1;
                bus.InstrRetire = 1'b1;
                state_d         = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcB     = SRCB_IMM;
                bus.ResultSrc   = RES_ALURES;
                bus.Branch      = 1'b1;
                bus.InstrRetire = 1'b1;
                state_d         = FETCH;
            end
            MULEX: begin
                bus.ALUOp     = 1'b1;
                bus.ALUSrcB   = SRCB_WD;
                bus.RegSrcMul = is_mul;
                // Counter was loaded with LAT-1 on entry, so LAT cycles here
                if (cnt_q == '0) state_d = MULWB;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            MULWB: begin
                bus.RegW        = 1'b1;
                bus.ResultSrc   = RES_ALUOUT;
                bus.lmulFlag    = bus.Funct[3];
                bus.RegSrcMul   = is_mul;
                bus.InstrRetire = 1'b1;
                state_d         = FETCH;
            end
            FPEX: begin
                if (cnt_q == '0) state_d = FPWB;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FPWB: begin
                bus.FpuW        = 1'b1;
                bus.InstrRetire = 1'b1;
                state_d         = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // While reset is held the state already reads FETCH; only the
        // enables need masking so nothing is written during reset.
        if (!reset) begin
            bus.IRWrite     = 1'b0;
            bus.NextPC      = 1'b0;
            bus.RegW        = 1'b0;
            bus.MemW        = 1'b0;
            bus.FpuW        = 1'b0;
            bus.InstrRetire = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_mainfsm.sv
// tb_mc_mainfsm: directed testbench for mc_mainfsm (MUL_LAT=3, FPU_LAT=2).
// Each cycle the full control vector is compared against a hand-written
// per-state constant.
// Vector layout: {NextPC,Branch,RegW,MemW,FpuW,IRWrite,AdrSrc}_
//                {ALUSrcA}_{ALUSrcB}_{ResultSrc}_{ALUOp,RegSrcMul,lmulFlag,InstrRetire}
module tb_mc_mainfsm;

    localparam logic [16:0] V_FETCH      = 17'b1000010_01_10_10_0000;
    localparam logic [16:0] V_RESET      = 17'b0000000_01_10_10_0000;
    localparam logic [16:0] V_DECODE     = 17'b0000000_01_10_10_0000;
    localparam logic [16:0] V_DECODE_MUL = 17'b0000000_01_10_10_0100;
    localparam logic [16:0] V_DECODE_UND = 17'b0000000_01_10_10_0001;
    localparam logic [16:0] V_EXECR      = 17'b0000000_00_00_00_1000;
    localparam logic [16:0] V_EXECI      = 17'b0000000_00_01_00_1000;
    localparam logic [16:0] V_ALUWB      = 17'b0010000_00_00_00_0001;
    localparam logic [16:0] V_MEMADR     = 17'b0000000_00_01_00_0000;
    localparam logic [16:0] V_MEMRD      = 17'b0000001_00_00_00_0000;
    localparam logic [16:0] V_MEMWB      = 17'b0010000_00_00_01_0001;
    localparam logic [16:0] V_MEMWR      = 17'b0001001_00_00_00_0001;
    localparam logic [16:0] V_BRANCH     = 17'b0100000_00_01_10_0001;
    localparam logic [16:0] V_MULEX      = 17'b0000000_00_00_00_1100;
    localparam logic [16:0] V_MULWB_L    = 17'b0010000_00_00_00_0111;
    localparam logic [16:0] V_MULWB      = 17'b0010000_00_00_00_0101;
    localparam logic [16:0] V_FPEX       = 17'b0000000_00_00_00_0000;
    localparam logic [16:0] V_FPWB       = 17'b0000100_00_00_00_0001;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mc_mainfsm_if bus();

    mc_mainfsm #(.MUL_LAT(3), .FPU_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] obs_vec();
        return {bus.NextPC, bus.Branch, bus.RegW, bus.MemW, bus.FpuW,
                bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ResultSrc, bus.ALUOp, bus.RegSrcMul, bus.lmulFlag,
                bus.InstrRetire};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (obs_vec() !== V_RESET) begin
                bad++;
                $display("FAIL reset_hold cyc%0d got=%b exp=%b", i, obs_vec(), V_RESET);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (obs_vec() !== V_FETCH) begin
            bad++;
            $display("FAIL reset_release got=%b exp=%b", obs_vec(), V_FETCH);
        end
        $display("reset: held 3 cycles, released into FETCH");
    endtask

    task automatic test_add();
        logic [16:0] exp [4] = '{V_FETCH, V_DECODE, V_EXECR, V_ALUWB};
        bus.Op = 2'b00; bus.Funct = 6'b001000; bus.MulBits = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL add cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        @(posedge clk); #1;
        $display("add r1,r2,r3: 4 cycles");
    endtask

    task automatic test_addi_mulbits();
        // MulBits=1001 but Funct[5]=1: immediate form, not a multiply
        logic [16:0] exp [4] = '{V_FETCH, V_DECODE, V_EXECI, V_ALUWB};
        bus.Op = 2'b00; bus.Funct = 6'b101000; bus.MulBits = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL addi cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        @(posedge clk); #1;
        $display("add imm: 4 cycles");
    endtask

    task automatic test_ldr();
        logic [16:0] exp [5] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
        bus.Op = 2'b01; bus.Funct = 6'b011001; bus.MulBits = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL ldr cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        @(posedge clk); #1;
        $display("ldr: 5 cycles");
    endtask

    task automatic test_str();
        logic [16:0] exp [4] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
        bus.Op = 2'b01; bus.Funct = 6'b011000; bus.MulBits = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL str cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        @(posedge clk); #1;
        $display("str: 4 cycles");
    endtask

    task automatic test_branch();
        logic [16:0] exp [3] = '{V_FETCH, V_DECODE, V_BRANCH};
        bus.Op = 2'b10; bus.Funct = 6'b100000; bus.MulBits = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL branch cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        @(posedge clk); #1;
        $display("b: 3 cycles");
    endtask

    task automatic test_umull();
        logic [16:0] exp [6] = '{V_FETCH, V_DECODE_MUL, V_MULEX, V_MULEX,
                                 V_MULEX, V_MULWB_L};
        bus.Op = 2'b00; bus.Funct = 6'b001001; bus.MulBits = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL umull cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        @(posedge clk); #1;
        $display("umull: 6 cycles (MUL_LAT=3)");
    endtask

    task automatic test_mul();
        logic [16:0] exp [6] = '{V_FETCH, V_DECODE_MUL, V_MULEX, V_MULEX,
                                 V_MULEX, V_MULWB};
        bus.Op = 2'b00; bus.Funct = 6'b000000; bus.MulBits = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL mul cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        @(posedge clk); #1;
        $display("mul: 6 cycles, single writeback");
    endtask

    task automatic test_fp();
        logic [16:0] exp [5] = '{V_FETCH, V_DECODE, V_FPEX, V_FPEX, V_FPWB};
        bus.Op = 2'b11; bus.Funct = 6'b100000; bus.MulBits = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL fp cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        @(posedge clk); #1;
        $display("fp op: 5 cycles (FPU_LAT=2)");
    endtask

    task automatic test_undef();
        logic [16:0] exp [3] = '{V_FETCH, V_DECODE_UND, V_FETCH};
        bus.Op = 2'b11; bus.Funct = 6'b000000; bus.MulBits = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL undef cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        $display("undefined op=11: back to FETCH, no writes");
    endtask

    task automatic test_reset_abort();
        logic [16:0] exp [4] = '{V_FETCH, V_DECODE_MUL, V_MULEX, V_MULEX};
        bus.Op = 2'b00; bus.Funct = 6'b001001; bus.MulBits = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            total++;
            if (obs_vec() !== exp[i]) begin
                bad++;
                $display("FAIL abort_pre cyc%0d got=%b exp=%b", i, obs_vec(), exp[i]);
            end
        end
        // In MULEX cycle 2: assert reset asynchronously
        #2 reset = 1'b0;
        #1;
        total++;
        if (obs_vec() !== V_RESET) begin
            bad++;
            $display("FAIL abort_async got=%b exp=%b", obs_vec(), V_RESET);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (obs_vec() !== V_RESET) begin
                bad++;
                $display("FAIL abort_hold cyc%0d got=%b exp=%b", i, obs_vec(), V_RESET);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (obs_vec() !== V_FETCH) begin
            bad++;
            $display("FAIL abort_release got=%b exp=%b", obs_vec(), V_FETCH);
        end
        $display("reset during MULEX: aborted to FETCH without RegW");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.Op      = 2'b00;
        bus.Funct   = 6'b000000;
        bus.MulBits = 4'b0000;
        #2 reset = 1'b0;

        test_reset();
        test_add();
        test_addi_mulbits();
        test_ldr();
        test_str();
        test_branch();
        test_umull();
        test_mul();
        test_fp();
        test_undef();
        test_reset_abort();
        test_umull();
        test_add();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
